ethernet_rx: RTL and testbench
==============================

# ethernet_rx

Receive-side Ethernet framer. It consumes the PHY dibit/nibble stream (RMII-style data plus data-valid) and locates preamble and SFD. It parses destination MAC, source MAC and EtherType, streams payload bytes downstream, and checks the FCS. It sits between the PHY input pins (after any CRS_DV cleanup) and the packet-processing logic, mirroring the transmit path.

## Interface
Parameters:
- `N`, default 2: wire-symbol width in bits; only 2 (RMII) and 4 (MII) are legal.

Ports:
- `clk`  in  1  data-rate clock (25/50 MHz); single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `axiiv`  in  1  wire data valid (cleaned CRS_DV / RX_DV).
- `axiid`  in  N  wire symbol; LSB-first within each byte, as on the wire.
- `my_mac`  in  48  this FPGA's MAC address (byte 0 = bits [47:40]).
- `axiov`  out  1  payload byte valid.
- `axiod`  out  8  payload byte.
- `src_mac`  out  48  source MAC of the current frame; held until the next header.
- `etype`  out  16  EtherType of the current frame; held until the next header.
- `hdr_valid`  out  1  one-cycle pulse when the 14-byte header is parsed and accepted.
- `frame_done`  out  1  one-cycle pulse at the end of every frame that reached HEADER.
- `frame_ok`  out  1  qualifies `frame_done`: 1 = FCS good and no errors.

## Operation
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
- **IDLE**: on `axiiv`=1 go to PREAMBLE.
- **PREAMBLE**:
  - Count preamble symbols: 2'b01 (N=2) or 4'h5 (N=4).
  - SFD symbol is 2'b11 / 4'hD. On SFD after ≥4 preamble symbols, go to HEADER and reset the byte counter and CRC.
  - Any other symbol, an early SFD, or `axiiv` falling → DROP. No `frame_done` is issued.
- **Byte assembly**: 8/N symbols per byte; the first symbol received lands in bits [N-1:0].
- **HEADER**:
  - Bytes 0–5 form dest MAC, 6–11 form `src_mac`, 12–13 form `etype` (big-endian).
  - After byte 5: mismatch → DROP (see Configuration).
  - After byte 13: pulse `hdr_valid`, go to PAYLOAD.
- **PAYLOAD**:
  - Every byte enters a 4-byte delay line.
  - Each byte pushed out of the delay line is emitted on `axiod` with `axiov`=1.
  - The four bytes held when `axiiv` falls are the FCS and are never emitted.
- **CRC**:
  - Reflected CRC-32 (poly 0xEDB88320), register initialised to 0xFFFFFFFF at SFD.
  - Updated N bits per valid symbol over every byte from dest MAC through FCS inclusive.
  - Frame is good iff the register equals 0xDEBB20E3 after the last FCS symbol.
- **End of frame** (`axiiv` falls in HEADER or PAYLOAD):
  - `frame_ok`=1 only if the CRC residue matches, the symbol count is a whole number of bytes, and the total length is 64–1522 bytes including FCS.
  - Then return to IDLE.
- **Length limit**: the byte counter is 11 bits and saturates at 2047. Exceeding 1522 bytes → DROP with `frame_ok`=0 reported at the end.
- **DROP**:
  - Suppress `axiov` and wait for `axiiv`=0, then go to IDLE.
  - If entered from HEADER or PAYLOAD, pulse `frame_done` with `frame_ok`=0.
- **Reset**: `rst` mid-frame aborts immediately with no `frame_done`. The next frame requires a fresh preamble.

## Timing
- Reset values: `axiov`=0, `axiod`=0, `src_mac`=0, `etype`=0, `hdr_valid`=0, `frame_done`=0, `frame_ok`=0; state IDLE.
- Symbols are sampled on every `clk` edge with `axiiv`=1. No stall or backpressure: downstream must accept one byte per 8/N cycles.
- `axiov` pulses one cycle after the final symbol of the byte that evicts the emitted byte, i.e. the payload byte received 4 bytes earlier.
- `hdr_valid` pulses one cycle after the final symbol of byte 13.
- `frame_done`/`frame_ok` assert one cycle after the first sample of `axiiv`=0. The last payload `axiov` always precedes `frame_done`.
- `axiiv` rising again in the cycle after `frame_done` is legal and starts PREAMBLE.

## Configuration
- `ETHERNET_RX_MAC_FILTER_EN` defined:
  - Accept a frame only if dest MAC equals `my_mac` or FF:FF:FF:FF:FF:FF.
  - Otherwise DROP after byte 5; `frame_done` is pulsed with `frame_ok`=0.
- Undefined: promiscuous. Every frame proceeds to PAYLOAD regardless of dest MAC; `my_mac` is unused.

## Test plan
- **Good unicast**, N=2: 7×0x55 + 0xD5, dest=`my_mac`, src=02:00:00:00:00:01, etype=0x0800, 46 bytes 0x00..0x2D, correct FCS → `hdr_valid` once, 46 `axiov` bytes 0x00..0x2D in order, `src_mac`/`etype` match, `frame_done`=1 with `frame_ok`=1, FCS bytes not emitted.
- **Corrupted FCS**: same frame with one payload bit flipped → 46 bytes emitted, `frame_ok`=0.
- **Filter**: with `ETHERNET_RX_MAC_FILTER_EN`, dest=02:00:00:00:00:99 ≠ `my_mac` → no `hdr_valid`, no `axiov`, `frame_ok`=0. Broadcast dest → accepted.
- **Runt and odd-dibit**: 40-byte frame with valid FCS → `frame_ok`=0. Valid frame plus one extra dibit → `frame_ok`=0.
- **Bad preamble and reset**:
  - Symbol 2'b00 inside the preamble → no `frame_done`, and the next good frame is received cleanly.
  - `rst` asserted during PAYLOAD → all outputs 0 next cycle, and the following frame decodes with `frame_ok`=1.
- **N=4**: repeat the good-unicast case on nibbles → identical byte output.

Source files
------------

// File: rtl/ethernet_rx.sv
// Receive-side Ethernet framer: preamble/SFD search, header parse, payload stream, FCS check.
// Define ETHERNET_RX_MAC_FILTER_EN to accept only frames addressed to my_mac or broadcast.
module ethernet_rx #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         axiiv,
    input  logic [N-1:0] axiid,
    input  logic [47:0]  my_mac,
    output logic         axiov,
    output logic [7:0]   axiod,
    output logic [47:0]  src_mac,
    output logic [15:0]  etype,
    output logic         hdr_valid,
    output logic         frame_done,
    output logic         frame_ok
);
    localparam int unsigned SymPerByte = 8 / N;
    localparam logic [1:0]  SymLast    = 2'(SymPerByte - 1);
    localparam logic [3:0]  PreNib     = 4'h5;
    localparam logic [3:0]  SfdNib     = (N == 2) ? 4'h3 : 4'hD;
    localparam logic [N-1:0] PreSym    = PreNib[N-1:0];
    localparam logic [N-1:0] SfdSym    = SfdNib[N-1:0];
    localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
    localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

    typedef enum logic [2:0] {StIdle, StPreamble, StHeader, StPayload, StDrop} state_e;

    state_e          r_state, w_state_next;
    logic [2:0]      r_pre_cnt;
    logic [1:0]      r_sym_cnt;
    logic [7-N:0]    r_shift;
    logic [31:0]     r_crc;
    logic [10:0]     r_byte_cnt;
    logic [55:0]     r_hdr_sh;
    logic [3:0][7:0] r_dly;
    logic [2:0]      r_dly_cnt;
    logic            r_drop_report;
    logic            r_axiov;
    logic [7:0]      r_axiod;
    logic [47:0]     r_src_mac;
    logic [15:0]     r_etype;
    logic            r_hdr_valid;
    logic            r_frame_done;
    logic            r_frame_ok;

    logic [7:0]  w_byte;
    logic [31:0] w_crc_next;
    logic        w_sym_last, w_dst_ok, w_len_ok, w_in_frame;
    logic        w_sfd, w_hdr, w_emit, w_done, w_ok, w_set_report;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [N-1:0] sym);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < N; i++) begin
            c = (c[0] ^ sym[i]) ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    // Symbols shift in from the top so the first one ends up in bits [N-1:0].
    assign w_byte     = {axiid, r_shift};
    assign w_crc_next = crc_step(r_crc, axiid);
    assign w_sym_last = (r_sym_cnt == SymLast);
    assign w_in_frame = (r_state == StHeader) || (r_state == StPayload);
    assign w_len_ok   = (r_byte_cnt >= 11'd64) && (r_byte_cnt <= 11'd1522);

`ifdef ETHERNET_RX_MAC_FILTER_EN
    logic [47:0] w_dst;
    assign w_dst    = {r_hdr_sh[39:0], w_byte};
    assign w_dst_ok = (w_dst == my_mac) || (w_dst == 48'hFFFF_FFFF_FFFF);
`else
    logic w_unused_mac;
    assign w_unused_mac = ^my_mac;
    assign w_dst_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sfd        = 1'b0;
        w_hdr        = 1'b0;
        w_emit       = 1'b0;
        w_done       = 1'b0;
        w_ok         = 1'b0;
        w_set_report = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (axiiv) w_state_next = (axiid == PreSym) ? StPreamble : StDrop;
            end
            StPreamble: begin
                if (!axiiv) begin
                    w_state_next = StDrop;
                end else if (axiid == SfdSym && r_pre_cnt == 3'd4) begin
                    w_state_next = StHeader;
                    w_sfd        = 1'b1;
                end else if (axiid != PreSym) begin
                    w_state_next = StDrop;
                end
            end
            StHeader: begin
                if (!axiiv) begin
                    w_state_next = StIdle;
                    w_done       = 1'b1;
                end else if (w_sym_last) begin
                    if (r_byte_cnt == 11'd5 && !w_dst_ok) begin
                        w_state_next = StDrop;
                        w_set_report = 1'b1;
                    end else if (r_byte_cnt == 11'd13) begin
                        w_state_next = StPayload;
                        w_hdr        = 1'b1;
                    end
                end
            end
            StPayload: begin
                if (!axiiv) begin
                    w_state_next = StIdle;
                    w_done       = 1'b1;
                    w_ok         = (r_crc == CrcResidue) && (r_sym_cnt == 2'd0) && w_len_ok;
                end else if (w_sym_last) begin
                    if (r_byte_cnt >= 11'd1522) begin
                        w_state_next = StDrop;
                        w_set_report = 1'b1;
                    end else begin
                        w_emit = (r_dly_cnt == 3'd4);
                    end
                end
            end
            StDrop: begin
                if (!axiiv) begin
                    w_state_next = StIdle;
                    w_done       = r_drop_report;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt     <= 3'd0;
            r_sym_cnt     <= 2'd0;
            r_shift       <= '0;
            r_crc         <= 32'hFFFF_FFFF;
            r_byte_cnt    <= 11'd0;
            r_hdr_sh      <= 56'd0;
            r_dly         <= '0;
            r_dly_cnt     <= 3'd0;
            r_drop_report <= 1'b0;
            r_axiov       <= 1'b0;
            r_axiod       <= 8'd0;
            r_src_mac     <= 48'd0;
            r_etype       <= 16'd0;
            r_hdr_valid   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
        end else begin
            r_hdr_valid  <= w_hdr;
            r_frame_done <= w_done;
            r_frame_ok   <= w_done & w_ok;
            r_axiov      <= w_emit;
            if (w_emit) r_axiod <= r_dly[3];

            if (r_state == StIdle) begin
                r_pre_cnt <= (axiid == PreSym) ? 3'd1 : 3'd0;
            end else if (r_state == StPreamble && axiiv && axiid == PreSym && r_pre_cnt != 3'd4) begin
                r_pre_cnt <= r_pre_cnt + 3'd1;
            end

            if (r_state == StIdle)  r_drop_report <= 1'b0;
            else if (w_set_report)  r_drop_report <= 1'b1;

            if (w_sfd) begin
                r_crc      <= 32'hFFFF_FFFF;
                r_byte_cnt <= 11'd0;
                r_sym_cnt  <= 2'd0;
                r_dly_cnt  <= 3'd0;
            end else if (axiiv && w_in_frame) begin
                r_crc     <= w_crc_next;
                r_shift   <= w_byte[7:N];
                r_sym_cnt <= w_sym_last ? 2'd0 : r_sym_cnt + 2'd1;
                if (w_sym_last) begin
                    if (r_byte_cnt != 11'h7FF) r_byte_cnt <= r_byte_cnt + 11'd1;
                    if (r_state == StHeader) begin
                        r_hdr_sh <= {r_hdr_sh[47:0], w_byte};
                    end else begin
                        // Four-byte delay line holds back what may turn out to be the FCS.
                        r_dly <= {r_dly[2:0], w_byte};
                        if (r_dly_cnt != 3'd4) r_dly_cnt <= r_dly_cnt + 3'd1;
                    end
                end
            end

            if (w_hdr) begin
                r_src_mac <= r_hdr_sh[55:8];
                r_etype   <= {r_hdr_sh[7:0], w_byte};
            end
        end
    end

    assign axiov      = r_axiov;
    assign axiod      = r_axiod;
    assign src_mac    = r_src_mac;
    assign etype      = r_etype;
    assign hdr_valid  = r_hdr_valid;
    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;

endmodule

// File: tb/tb_ethernet_rx.sv
// Scoreboard bench for ethernet_rx: an RMII (N=2) and an MII (N=4) instance fed byte-built frames.
module tb_ethernet_rx;
    typedef logic [7:0] byte_q_t[$];

    localparam logic [47:0] MyMac    = 48'h02_00_00_00_00_42;
    localparam logic [47:0] SrcMac   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OtherMac = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BcastMac = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] EType    = 16'h0800;

    logic clk;
    logic rst;
    logic iv2, iv4;
    logic [1:0] d2;
    logic [3:0] d4;
    logic ov2, ov4, hv2, hv4, fd2, fd4, fo2, fo4;
    logic [7:0] od2, od4;
    logic [47:0] src2, src4;
    logic [15:0] et2, et4;

    logic [7:0]  exp_b2[$], exp_b4[$];
    logic [63:0] exp_h2[$], exp_h4[$];
    logic        exp_ok2[$], exp_ok4[$];

    int n_tests = 0;
    int n_fail  = 0;
    byte_q_t f;

    ethernet_rx #(.N(2)) u_dut2 (
        .clk(clk), .rst(rst), .axiiv(iv2), .axiid(d2), .my_mac(MyMac),
        .axiov(ov2), .axiod(od2), .src_mac(src2), .etype(et2),
        .hdr_valid(hv2), .frame_done(fd2), .frame_ok(fo2)
    );

    ethernet_rx #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .axiiv(iv4), .axiid(d4), .my_mac(MyMac),
        .axiov(ov4), .axiod(od4), .src_mac(src4), .etype(et4),
        .hdr_valid(hv4), .frame_done(fd4), .frame_ok(fo4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rst(input string p, input logic ov, input logic [7:0] od,
                             input logic [47:0] sm, input logic [15:0] et,
                             input logic hv, input logic fd, input logic fo);
        check_val({p, "_rst_axiov"}, 64'(ov), 64'd0);
        check_val({p, "_rst_axiod"}, 64'(od), 64'd0);
        check_val({p, "_rst_src_mac"}, 64'(sm), 64'd0);
        check_val({p, "_rst_etype"}, 64'(et), 64'd0);
        check_val({p, "_rst_hdr_valid"}, 64'(hv), 64'd0);
        check_val({p, "_rst_frame_done"}, 64'(fd), 64'd0);
        check_val({p, "_rst_frame_ok"}, 64'(fo), 64'd0);
    endtask

    always @(negedge clk) begin
        if (ov2 === 1'b1) begin
            if (exp_b2.size() == 0) check_val("n2_axiov_unexpected", 64'(ov2), 64'd0);
            else                    check_val("n2_axiod", 64'(od2), 64'(exp_b2.pop_front()));
        end
        if (hv2 === 1'b1) begin
            if (exp_h2.size() == 0) check_val("n2_hdr_valid_unexpected", 64'(hv2), 64'd0);
            else                    check_val("n2_src_etype", {src2, et2}, exp_h2.pop_front());
        end
        if (fd2 === 1'b1) begin
            if (exp_ok2.size() == 0) check_val("n2_frame_done_unexpected", 64'(fd2), 64'd0);
            else                     check_val("n2_frame_ok", 64'(fo2), 64'(exp_ok2.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (ov4 === 1'b1) begin
            if (exp_b4.size() == 0) check_val("n4_axiov_unexpected", 64'(ov4), 64'd0);
            else                    check_val("n4_axiod", 64'(od4), 64'(exp_b4.pop_front()));
        end
        if (hv4 === 1'b1) begin
            if (exp_h4.size() == 0) check_val("n4_hdr_valid_unexpected", 64'(hv4), 64'd0);
            else                    check_val("n4_src_etype", {src4, et4}, exp_h4.pop_front());
        end
        if (fd4 === 1'b1) begin
            if (exp_ok4.size() == 0) check_val("n4_frame_done_unexpected", 64'(fd4), 64'd0);
            else                     check_val("n4_frame_ok", 64'(fo4), 64'(exp_ok4.pop_front()));
        end
    end

    // dst, SrcMac, EType, payload 0,1,2,..., then FCS (complemented reflected CRC, LSB byte first).
    function automatic byte_q_t build_frame(input logic [47:0] dst, input int npay);
        byte_q_t     q;
        logic [31:0] crc;
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) q.push_back(SrcMac[47-8*i -: 8]);
        q.push_back(EType[15:8]);
        q.push_back(EType[7:0]);
        for (int i = 0; i < npay; i++) q.push_back(i[7:0]);
        crc = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            crc = crc ^ {24'd0, q[i]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) q.push_back(crc[8*i +: 8]);
        return q;
    endfunction

    task automatic expect_frame(input bit n4, input byte_q_t fr, input bit hdr, input int nbytes,
                                input bit done, input bit ok);
        if (hdr) begin
            if (n4) exp_h4.push_back({SrcMac, EType});
            else    exp_h2.push_back({SrcMac, EType});
        end
        for (int i = 0; i < nbytes; i++) begin
            if (n4) exp_b4.push_back(fr[14+i]);
            else    exp_b2.push_back(fr[14+i]);
        end
        if (done) begin
            if (n4) exp_ok4.push_back(ok);
            else    exp_ok2.push_back(ok);
        end
    endtask

    task automatic drive2(input byte_q_t fr, input int extra, input int bad_idx, input int abort_idx);
        byte_q_t all;
        int      s;
        bit      stop;
        all  = {};
        s    = 0;
        stop = 1'b0;
        repeat (7) all.push_back(8'h55);
        all.push_back(8'hD5);
        foreach (fr[i]) all.push_back(fr[i]);
        foreach (all[i]) begin
            for (int k = 0; k < 4; k++) begin
                if (!stop) begin
                    @(negedge clk);
                    iv2 = 1'b1;
                    d2  = (s == bad_idx) ? 2'b00 : all[i][2*k +: 2];
                    if (s == abort_idx) begin
                        rst  = 1'b1;
                        stop = 1'b1;
                        @(negedge clk);
                        check_rst("n2_mid", ov2, od2, src2, et2, hv2, fd2, fo2);
                        rst = 1'b0;
                        iv2 = 1'b0;
                    end
                    s++;
                end
            end
        end
        if (!stop) begin
            for (int e = 0; e < extra; e++) begin
                @(negedge clk);
                d2 = 2'b00;
            end
        end
        @(negedge clk);
        iv2 = 1'b0;
        d2  = 2'b00;
        repeat (16) @(negedge clk);
    endtask

    task automatic drive4(input byte_q_t fr);
        byte_q_t all;
        all = {};
        repeat (7) all.push_back(8'h55);
        all.push_back(8'hD5);
        foreach (fr[i]) all.push_back(fr[i]);
        foreach (all[i]) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                iv4 = 1'b1;
                d4  = all[i][4*k +: 4];
            end
        end
        @(negedge clk);
        iv4 = 1'b0;
        d4  = 4'h0;
        repeat (16) @(negedge clk);
    endtask

    task automatic end_test(input string name);
        check_val({name, "_n2_bytes_left"}, 64'(exp_b2.size()), 64'd0);
        check_val({name, "_n2_hdr_left"}, 64'(exp_h2.size()), 64'd0);
        check_val({name, "_n2_done_left"}, 64'(exp_ok2.size()), 64'd0);
        check_val({name, "_n4_bytes_left"}, 64'(exp_b4.size()), 64'd0);
        check_val({name, "_n4_hdr_left"}, 64'(exp_h4.size()), 64'd0);
        check_val({name, "_n4_done_left"}, 64'(exp_ok4.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        iv2 = 1'b0;
        d2  = 2'b00;
        iv4 = 1'b0;
        d4  = 4'h0;
        repeat (4) @(negedge clk);
        check_rst("n2", ov2, od2, src2, et2, hv2, fd2, fo2);
        check_rst("n4", ov4, od4, src4, et4, hv4, fd4, fo4);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        f = build_frame(MyMac, 46);
        expect_frame(1'b0, f, 1'b1, 46, 1'b1, 1'b1);
        drive2(f, 0, -1, -1);
        end_test("good");

        f = build_frame(MyMac, 46);
        f[24] = f[24] ^ 8'h04;
        expect_frame(1'b0, f, 1'b1, 46, 1'b1, 1'b0);
        drive2(f, 0, -1, -1);
        end_test("bad_fcs");

        f = build_frame(OtherMac, 46);
`ifdef ETHERNET_RX_MAC_FILTER_EN
        expect_frame(1'b0, f, 1'b0, 0, 1'b1, 1'b0);
`else
        expect_frame(1'b0, f, 1'b1, 46, 1'b1, 1'b1);
`endif
        drive2(f, 0, -1, -1);
        end_test("other_dest");

        f = build_frame(BcastMac, 46);
        expect_frame(1'b0, f, 1'b1, 46, 1'b1, 1'b1);
        drive2(f, 0, -1, -1);
        end_test("broadcast");

        f = build_frame(MyMac, 22);
        expect_frame(1'b0, f, 1'b1, 22, 1'b1, 1'b0);
        drive2(f, 0, -1, -1);
        end_test("runt");

        f = build_frame(MyMac, 46);
        expect_frame(1'b0, f, 1'b1, 46, 1'b1, 1'b0);
        drive2(f, 1, -1, -1);
        end_test("odd_dibit");

        f = build_frame(MyMac, 46);
        drive2(f, 0, 10, -1);
        end_test("bad_preamble");

        f = build_frame(MyMac, 46);
        expect_frame(1'b0, f, 1'b1, 46, 1'b1, 1'b1);
        drive2(f, 0, -1, -1);
        end_test("after_bad_pre");

        // Abort in the middle of payload byte 20: only payload bytes 0..15 have left the delay line.
        f = build_frame(MyMac, 46);
        expect_frame(1'b0, f, 1'b1, 16, 1'b0, 1'b0);
        drive2(f, 0, -1, (8 + 14 + 20) * 4 + 2);
        end_test("reset_abort");

        f = build_frame(MyMac, 46);
        expect_frame(1'b0, f, 1'b1, 46, 1'b1, 1'b1);
        drive2(f, 0, -1, -1);
        end_test("after_reset");

        f = build_frame(MyMac, 46);
        expect_frame(1'b1, f, 1'b1, 46, 1'b1, 1'b1);
        drive4(f);
        end_test("mii_good");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
